// File: rtl/game_fsm.sv
// Race game sequencer: title, countdown, play and game-over screens.
// Optional START_BLINK_EN macro blinks the title "Start" overlay every 16 frames.
module game_fsm #(
    parameter int COUNT_FRAMES = 60,
    parameter int OVER_FRAMES  = 120,
    parameter int SCORE_MAX    = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        btn_start,
    input  logic        crash,
    output logic        start_en,
    output logic        play_en,
    output logic        over_en,
    output logic [1:0]  count_digit,
    output logic [13:0] score
);

    localparam logic [2:0] S_TITLE = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_OVER  = 3'd3;

    localparam logic [7:0]  CF_LAST = 8'(COUNT_FRAMES - 1);
    localparam logic [7:0]  OF_LAST = 8'(OVER_FRAMES - 1);
    localparam logic [13:0] SMAX    = 14'(SCORE_MAX);

    logic [2:0]  r_state;
    logic [7:0]  r_frame;
    logic        r_btn_d;
    logic        r_arm;

    logic [2:0]  w_state_nxt;
    logic [7:0]  w_frame_nxt;
    logic [1:0]  w_digit_nxt;
    logic [13:0] w_score_nxt;
    logic        w_start;
    logic        w_start_en_nxt;

    // r_arm masks a button already held when reset releases
    assign w_start = r_arm & btn_start & ~r_btn_d;

    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = r_frame;
        w_digit_nxt = count_digit;
        w_score_nxt = score;
        case (r_state)
            S_TITLE: begin
                if (w_start) begin
                    w_state_nxt = S_COUNT;
                    w_frame_nxt = 8'd0;
                    w_digit_nxt = 2'd3;
                    w_score_nxt = 14'd0;
                end
            end
            S_COUNT: begin
                if (tick) begin
                    if (r_frame == CF_LAST) begin
                        w_frame_nxt = 8'd0;
                        if (count_digit == 2'd1) begin
                            w_state_nxt = S_PLAY;
                            w_digit_nxt = 2'd0;
                        end else begin
                            w_digit_nxt = count_digit - 2'd1;
                        end
                    end else begin
                        w_frame_nxt = r_frame + 8'd1;
                    end
                end
            end
            S_PLAY: begin
                if (crash) begin
                    w_state_nxt = S_OVER;
                    w_frame_nxt = 8'd0;
                end else if (tick && score != SMAX) begin
                    w_score_nxt = score + 14'd1;
                end
            end
            S_OVER: begin
                if (w_start) begin
                    w_state_nxt = S_COUNT;
                    w_frame_nxt = 8'd0;
                    w_digit_nxt = 2'd3;
                    w_score_nxt = 14'd0;
                end else if (tick) begin
                    if (r_frame == OF_LAST) begin
                        w_state_nxt = S_TITLE;
                        w_frame_nxt = 8'd0;
                    end else begin
                        w_frame_nxt = r_frame + 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_TITLE;
                w_frame_nxt = 8'd0;
                w_digit_nxt = 2'd0;
            end
        endcase
    end

`ifdef START_BLINK_EN
    logic [4:0] r_blink;
    logic [4:0] w_blink_nxt;

    always_comb begin
        w_blink_nxt = r_blink;
        if (r_state != S_TITLE || w_state_nxt != S_TITLE) begin
            w_blink_nxt = 5'd0;
        end else if (tick) begin
            w_blink_nxt = r_blink + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink <= 5'd0;
        end else begin
            r_blink <= w_blink_nxt;
        end
    end

    assign w_start_en_nxt = (w_state_nxt == S_TITLE) & ~w_blink_nxt[4];
`else
    assign w_start_en_nxt = (w_state_nxt == S_TITLE);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_TITLE;
            r_frame     <= 8'd0;
            r_btn_d     <= 1'b0;
            r_arm       <= 1'b0;
            start_en    <= 1'b1;
            play_en     <= 1'b0;
            over_en     <= 1'b0;
            count_digit <= 2'd0;
            score       <= 14'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame     <= w_frame_nxt;
            r_btn_d     <= btn_start;
            r_arm       <= 1'b1;
            start_en    <= w_start_en_nxt;
            play_en     <= (w_state_nxt == S_PLAY);
            over_en     <= (w_state_nxt == S_OVER);
            count_digit <= w_digit_nxt;
            score       <= w_score_nxt;
        end
    end

endmodule

// File: tb/tb_game_fsm.sv
// Bench for game_fsm: directed race scenarios then random traffic
// against a phase/tick-count model, on a default and a small-parameter instance.
module tb_game_fsm;

    typedef struct packed {
        int ph;     // 0 title, 1 countdown, 2 race, 3 game over
        int t;      // ticks since entering countdown / game over
        int tt;     // ticks since entering title, mod 32
        int score;
        bit prev;
        bit armed;
    } mdl_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b0;
    logic btn_start = 1'b0;
    logic crash = 1'b0;

    logic        d0_se, d0_pe, d0_oe;
    logic [1:0]  d0_cd;
    logic [13:0] d0_sc;
    logic        d1_se, d1_pe, d1_oe;
    logic [1:0]  d1_cd;
    logic [13:0] d1_sc;

    int n_cmp = 0;
    int n_bad = 0;
    mdl_t m0, m1;

    game_fsm u_dut (
        .clk(clk), .reset(reset), .tick(tick),
        .btn_start(btn_start), .crash(crash),
        .start_en(d0_se), .play_en(d0_pe), .over_en(d0_oe),
        .count_digit(d0_cd), .score(d0_sc)
    );

    game_fsm #(
        .COUNT_FRAMES(2), .OVER_FRAMES(3), .SCORE_MAX(5)
    ) u_sat (
        .clk(clk), .reset(reset), .tick(tick),
        .btn_start(btn_start), .crash(crash),
        .start_en(d1_se), .play_en(d1_pe), .over_en(d1_oe),
        .count_digit(d1_cd), .score(d1_sc)
    );

    always #5 clk = ~clk;

    function automatic mdl_t mres();
        mdl_t m;
        m = '0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit tk, bit b, bit cr,
                                   int cf, int of, int smax);
        mdl_t n;
        bit ev;
        n = m;
        ev = b && !m.prev && m.armed;
        n.prev = b;
        n.armed = 1'b1;
        if (m.ph == 0) begin
            if (ev) begin
                n.ph = 1; n.t = 0; n.score = 0;
            end else if (tk) begin
                n.tt = (m.tt + 1) % 32;
            end
        end else if (m.ph == 1) begin
            if (tk) begin
                n.t = m.t + 1;
                if (n.t == 3 * cf) n.ph = 2;
            end
        end else if (m.ph == 2) begin
            if (cr) begin
                n.ph = 3; n.t = 0;
            end else if (tk) begin
                n.score = (m.score + 1 > smax) ? smax : m.score + 1;
            end
        end else begin
            if (ev) begin
                n.ph = 1; n.t = 0; n.score = 0;
            end else if (tk) begin
                n.t = m.t + 1;
                if (n.t == of) begin
                    n.ph = 0; n.tt = 0;
                end
            end
        end
        return n;
    endfunction

    task automatic cmp(input string tg, input logic [13:0] obs,
                       input logic [13:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tg, obs, exp);
        end
    endtask

    task automatic chk(input string tg, input logic se, input logic pe,
                       input logic oe, input logic [1:0] cd,
                       input logic [13:0] sc, input mdl_t m, input int cf);
        logic e_se;
        logic [1:0] e_cd;
`ifdef START_BLINK_EN
        e_se = (m.ph == 0) && ((m.tt / 16) % 2 == 0);
`else
        e_se = (m.ph == 0);
`endif
        e_cd = (m.ph == 1) ? 2'(3 - m.t / cf) : 2'd0;
        cmp({tg, "/start_en"}, 14'(se), 14'(e_se));
        cmp({tg, "/play_en"}, 14'(pe), 14'(m.ph == 2));
        cmp({tg, "/over_en"}, 14'(oe), 14'(m.ph == 3));
        cmp({tg, "/digit"}, 14'(cd), 14'(e_cd));
        cmp({tg, "/score"}, sc, 14'(m.score));
    endtask

    task automatic chk_all(input string tg);
        chk({tg, "/d0"}, d0_se, d0_pe, d0_oe, d0_cd, d0_sc, m0, 60);
        chk({tg, "/d1"}, d1_se, d1_pe, d1_oe, d1_cd, d1_sc, m1, 2);
    endtask

    task automatic step(input bit tk, input bit b, input bit cr);
        tick = tk;
        btn_start = b;
        crash = cr;
        @(posedge clk);
        m0 = mstep(m0, tk, b, cr, 60, 120, 9999);
        m1 = mstep(m1, tk, b, cr, 2, 3, 5);
        #1;
        chk_all("step");
    endtask

    // Async reset mid-cycle; outputs must settle before the next edge
    task automatic do_reset(input string tg);
        #($urandom_range(1, 3));
        reset = 1'b1;
        #1;
        m0 = mres();
        m1 = mres();
        chk_all(tg);
        cmp({tg, "/rst_start_en"}, 14'(d0_se), 14'd1);
        cmp({tg, "/rst_score"}, d0_sc, 14'd0);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        m0 = mres();
        m1 = mres();
        @(posedge clk);
        #1;
        chk_all("reset");
        reset = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0);

        // title blink pattern over 48 ticks
        for (int i = 1; i <= 48; i++) begin
            step(1'b1, 1'b0, 1'b0);
`ifdef START_BLINK_EN
            if (i == 16) cmp("blink16", 14'(d0_se), 14'd0);
            if (i == 32) cmp("blink32", 14'(d0_se), 14'd1);
`else
            if (i == 16) cmp("steady16", 14'(d0_se), 14'd1);
`endif
        end

        step(1'b0, 1'b1, 1'b0);
        cmp("cnt_entry_digit", 14'(d0_cd), 14'd3);
        cmp("cnt_entry_se", 14'(d0_se), 14'd0);
        for (int i = 1; i <= 180; i++) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b0);
            if (i == 60) cmp("digit_after60", 14'(d0_cd), 14'd2);
            if (i == 120) cmp("digit_after120", 14'(d0_cd), 14'd1);
        end
        cmp("play_after180", 14'(d0_pe), 14'd1);
        cmp("digit_in_play", 14'(d0_cd), 14'd0);
        cmp("sat_score", d1_sc, 14'd5);
        cmp("held_btn_no_restart", 14'(d1_pe), 14'd1);

        step(1'b0, 1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b0, 1'b0);
        cmp("score10", d0_sc, 14'd10);
        step(1'b1, 1'b0, 1'b1);
        cmp("crash_tick_score", d0_sc, 14'd10);
        cmp("crash_over_en", 14'(d0_oe), 14'd1);

        repeat (120) step(1'b1, 1'b0, 1'b0);
        cmp("over_timeout_se", 14'(d0_se), 14'd1);
        cmp("over_timeout_oe", 14'(d0_oe), 14'd0);
        cmp("title_score_kept", d0_sc, 14'd10);

        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        repeat (180) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        repeat (4) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        cmp("over_restart_digit", 14'(d0_cd), 14'd3);
        cmp("over_restart_score", d0_sc, 14'd0);

        repeat (50) step(1'b1, 1'b0, 1'b0);
        do_reset("rst_in_count");
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        repeat (185) step(1'b1, 1'b1, 1'b0);
        do_reset("rst_in_play");
        step(1'b0, 1'b1, 1'b0);
        cmp("held_across_reset", 14'(d0_se), 14'd1);
        step(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 5000; i++) begin
            bit b;
            b = ($urandom_range(0, 7) == 0) ? ~btn_start : btn_start;
            step(1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 11) == 0));
            if ($urandom_range(0, 299) == 0) do_reset("rst_random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
